// File: rtl/sobel_filter_engine_if.sv
// Source/destination BRAM port bundle of the 3x3 filter engine.
// The engine is the master; the memories sit on the slave side.
interface sobel_filter_engine_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  o_src_ce;
    logic [ADDR_WIDTH-1:0] o_src_addr;
    logic [DATA_WIDTH-1:0] i_src_q;
    logic                  o_dst_ce;
    logic                  o_dst_we;
    logic [ADDR_WIDTH-1:0] o_dst_addr;
    logic [DATA_WIDTH-1:0] o_dst_d;

    modport master (
        output o_src_ce, o_src_addr,
        input  i_src_q,
        output o_dst_ce, o_dst_we, o_dst_addr, o_dst_d
    );

    modport slave (
        input  o_src_ce, o_src_addr,
        output i_src_q,
        input  o_dst_ce, o_dst_we, o_dst_addr, o_dst_d
    );
endinterface

// File: rtl/sobel_filter_engine.sv
// Single-pass 3x3 neighbourhood filter: copy, Sobel magnitude, Sobel threshold or Laplacian.
// Streams the source once through two line buffers and writes a full-size result image.
module sobel_filter_engine #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned IMAGE_WIDTH  = 100,
    parameter int unsigned IMAGE_HEIGHT = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_threshold,
    output logic                  o_idle,
    output logic                  o_read,
    output logic                  o_write,
    output logic                  o_done,
    sobel_filter_engine_if.master io_bram
);

    localparam int unsigned NPix = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned ColW = $clog2(IMAGE_WIDTH);
    localparam int unsigned RowW = $clog2(IMAGE_HEIGHT);
    localparam int unsigned SumW = DATA_WIDTH + 4;

    localparam logic [ADDR_WIDTH-1:0] LastAddr    = ADDR_WIDTH'(NPix - 1);
    localparam logic [ADDR_WIDTH-1:0] FlushBase   = ADDR_WIDTH'(NPix - IMAGE_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] FirstCentre = ADDR_WIDTH'(IMAGE_WIDTH + 1);
    localparam logic [ColW-1:0]       LastCol     = ColW'(IMAGE_WIDTH - 1);
    localparam logic [RowW-1:0]       LastRow     = RowW'(IMAGE_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] PixMax      = {DATA_WIDTH{1'b1}};

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StFlush, StDone} state_e;

    state_e                r_state, w_state_d;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_thr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_drain_cnt;
    logic [ADDR_WIDTH-1:0] r_flush_addr;

    // Pipeline: B = source data returning, C = window holds pixel r_c_idx, D = write register.
    logic                  r_b_valid, r_c_valid;
    logic [ADDR_WIDTH-1:0] r_b_idx, r_c_idx;
    logic [ColW-1:0]       r_lb_ptr;
    logic [ColW-1:0]       r_ccol;
    logic [RowW-1:0]       r_crow;
    logic                  r_d_we;
    logic [ADDR_WIDTH-1:0] r_d_addr;
    logic [DATA_WIDTH-1:0] r_d_data;

    logic [DATA_WIDTH-1:0] r_win [3][3];
    logic [DATA_WIDTH-1:0] r_lb0 [IMAGE_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb1 [IMAGE_WIDTH];

    logic                  w_emit_copy, w_emit_filt, w_border, w_flush, w_dst_we;
    logic signed [SumW-1:0] w_gx, w_gy, w_lap;
    logic [SumW-1:0]       w_gx_abs, w_gy_abs;
    logic [SumW:0]         w_mag_sum;
    logic [DATA_WIDTH-1:0] w_mag, w_lap_sat, w_result;

    function automatic logic signed [SumW-1:0] zx(input logic [DATA_WIDTH-1:0] v);
        return $signed({{(SumW - DATA_WIDTH){1'b0}}, v});
    endfunction

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_run) w_state_d = StRead;
            StRead:  if (r_addr == LastAddr) w_state_d = StDrain;
            StDrain: if (r_drain_cnt == 2'd2) w_state_d = (r_mode == 2'd0) ? StDone : StFlush;
            StFlush: if (r_flush_addr == LastAddr) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    assign w_emit_copy = r_c_valid && (r_mode == 2'd0);
    assign w_emit_filt = r_c_valid && (r_mode != 2'd0) && (r_c_idx >= FirstCentre);
    assign w_border    = (r_ccol == '0) || (r_ccol == LastCol) ||
                         (r_crow == '0) || (r_crow == LastRow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_mode       <= '0;
            r_thr        <= '0;
            r_addr       <= '0;
            r_drain_cnt  <= '0;
            r_flush_addr <= FlushBase;
            r_b_valid    <= 1'b0;
            r_c_valid    <= 1'b0;
            r_b_idx      <= '0;
            r_c_idx      <= '0;
            r_lb_ptr     <= '0;
            r_ccol       <= '0;
            r_crow       <= '0;
            r_d_we       <= 1'b0;
            r_d_addr     <= '0;
            r_d_data     <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && i_run) begin
                r_mode <= i_mode;
                r_thr  <= i_threshold;
            end
            r_addr       <= (r_state == StRead && w_state_d == StRead) ?
                            r_addr + ADDR_WIDTH'(1) : '0;
            r_drain_cnt  <= (r_state == StDrain) ? r_drain_cnt + 2'd1 : 2'd0;
            r_flush_addr <= (r_state == StFlush) ? r_flush_addr + ADDR_WIDTH'(1) : FlushBase;

            r_b_valid <= (r_state == StRead);
            r_b_idx   <= r_addr;
            r_c_valid <= r_b_valid;
            r_c_idx   <= r_b_idx;

            if (r_state == StIdle) begin
                r_lb_ptr <= '0;
            end else if (r_b_valid) begin
                r_lb_ptr <= (r_lb_ptr == LastCol) ? '0 : r_lb_ptr + ColW'(1);
            end

            // Centre coordinates follow each emitted filter result in raster order.
            if (r_state == StIdle) begin
                r_ccol <= '0;
                r_crow <= '0;
            end else if (w_emit_filt) begin
                if (r_ccol == LastCol) begin
                    r_ccol <= '0;
                    r_crow <= r_crow + RowW'(1);
                end else begin
                    r_ccol <= r_ccol + ColW'(1);
                end
            end

            r_d_we   <= w_emit_copy | w_emit_filt;
            r_d_addr <= w_emit_copy ? r_c_idx :
                        (w_emit_filt ? r_c_idx - FirstCentre : '0);
            r_d_data <= w_emit_copy ? r_win[2][2] : (w_emit_filt ? w_result : '0);
        end
    end

    // Window and line buffers carry no state that matters across passes.
    always_ff @(posedge clk) begin
        if (r_b_valid) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[2][2]     <= io_bram.i_src_q;
            r_win[1][2]     <= r_lb1[r_lb_ptr];
            r_win[0][2]     <= r_lb0[r_lb_ptr];
            r_lb1[r_lb_ptr] <= io_bram.i_src_q;
            r_lb0[r_lb_ptr] <= r_lb1[r_lb_ptr];
        end
    end

    assign w_gx = (zx(r_win[0][2]) + (zx(r_win[1][2]) <<< 1) + zx(r_win[2][2])) -
                  (zx(r_win[0][0]) + (zx(r_win[1][0]) <<< 1) + zx(r_win[2][0]));
    assign w_gy = (zx(r_win[2][0]) + (zx(r_win[2][1]) <<< 1) + zx(r_win[2][2])) -
                  (zx(r_win[0][0]) + (zx(r_win[0][1]) <<< 1) + zx(r_win[0][2]));
    assign w_gx_abs  = w_gx[SumW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    assign w_gy_abs  = w_gy[SumW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    assign w_mag_sum = {1'b0, w_gx_abs} + {1'b0, w_gy_abs};
    assign w_mag     = (|w_mag_sum[SumW:DATA_WIDTH]) ? PixMax : w_mag_sum[DATA_WIDTH-1:0];

    assign w_lap = (zx(r_win[1][1]) <<< 2) -
                   (zx(r_win[0][1]) + zx(r_win[1][0]) + zx(r_win[1][2]) + zx(r_win[2][1]));
    assign w_lap_sat = w_lap[SumW-1] ? '0 :
                       ((|w_lap[SumW-2:DATA_WIDTH]) ? PixMax : w_lap[DATA_WIDTH-1:0]);

    always_comb begin
        w_result = '0;
        if (!w_border) begin
            unique case (r_mode)
                2'd1:    w_result = w_mag;
                2'd2:    w_result = (w_mag >= r_thr) ? PixMax : '0;
                2'd3:    w_result = w_lap_sat;
                default: w_result = '0;
            endcase
        end
    end

    // The last W+1 centres are all border pixels, so FLUSH writes zeros directly.
    assign w_flush  = (r_state == StFlush);
    assign w_dst_we = r_d_we | w_flush;

    assign o_idle  = (r_state == StIdle);
    assign o_read  = (r_state == StRead);
    assign o_done  = (r_state == StDone);
    assign o_write = w_dst_we;

    assign io_bram.o_src_ce   = (r_state == StRead);
    assign io_bram.o_src_addr = r_addr;
    assign io_bram.o_dst_ce   = w_dst_we;
    assign io_bram.o_dst_we   = w_dst_we;
    assign io_bram.o_dst_addr = w_flush ? r_flush_addr : r_d_addr;
    assign io_bram.o_dst_d    = w_flush ? '0 : r_d_data;

endmodule

// File: tb/tb_sobel_filter_engine.sv
// Bench for sobel_filter_engine: three engine sizes share one source/destination memory model;
// a 2-D reference model predicts every cycle of each pass.
module tb_sobel_filter_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [1:0] mode;
    logic [7:0] thr;
    int         sel;
    logic [2:0] idle_v, read_v, write_v, done_v;

    sobel_filter_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus_a ();
    sobel_filter_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus_b ();
    sobel_filter_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus_c ();

    sobel_filter_engine #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_run(run && sel == 0), .i_mode(mode), .i_threshold(thr),
        .o_idle(idle_v[0]), .o_read(read_v[0]), .o_write(write_v[0]), .o_done(done_v[0]),
        .io_bram(bus_a)
    );

    sobel_filter_engine #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .IMAGE_WIDTH(6), .IMAGE_HEIGHT(5)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_run(run && sel == 1), .i_mode(mode), .i_threshold(thr),
        .o_idle(idle_v[1]), .o_read(read_v[1]), .o_write(write_v[1]), .o_done(done_v[1]),
        .io_bram(bus_b)
    );

    sobel_filter_engine #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .i_run(run && sel == 2), .i_mode(mode), .i_threshold(thr),
        .o_idle(idle_v[2]), .o_read(read_v[2]), .o_write(write_v[2]), .o_done(done_v[2]),
        .io_bram(bus_c)
    );

    always #5 clk = ~clk;

    logic [7:0] src_mem [64];
    logic [7:0] dst_mem [64];
    int         wr_cnt  [64];
    int         exp_img [64];
    int         cur_w, cur_h, n_pix, d_exp, cyc, done_cyc;
    bit         active;
    int         n_checks, n_errors;

    // Source BRAM: data valid one cycle after the address.
    always @(posedge clk) begin
        if (bus_a.o_src_ce) bus_a.i_src_q <= src_mem[bus_a.o_src_addr[5:0]];
        if (bus_b.o_src_ce) bus_b.i_src_q <= src_mem[bus_b.o_src_addr[5:0]];
        if (bus_c.o_src_ce) bus_c.i_src_q <= src_mem[bus_c.o_src_addr[5:0]];
    end

    logic        m_idle, m_read, m_write, m_done, m_src_ce, m_dst_ce, m_dst_we;
    logic [15:0] m_src_addr, m_dst_addr;
    logic [7:0]  m_dst_d;

    always_comb begin
        m_idle  = idle_v[0];
        m_read  = read_v[0];
        m_write = write_v[0];
        m_done  = done_v[0];
        {m_src_ce, m_src_addr, m_dst_ce, m_dst_we, m_dst_addr, m_dst_d} =
            {bus_a.o_src_ce, bus_a.o_src_addr, bus_a.o_dst_ce, bus_a.o_dst_we,
             bus_a.o_dst_addr, bus_a.o_dst_d};
        if (sel == 1) begin
            {m_idle, m_read, m_write, m_done} = {idle_v[1], read_v[1], write_v[1], done_v[1]};
            {m_src_ce, m_src_addr, m_dst_ce, m_dst_we, m_dst_addr, m_dst_d} =
                {bus_b.o_src_ce, bus_b.o_src_addr, bus_b.o_dst_ce, bus_b.o_dst_we,
                 bus_b.o_dst_addr, bus_b.o_dst_d};
        end else if (sel == 2) begin
            {m_idle, m_read, m_write, m_done} = {idle_v[2], read_v[2], write_v[2], done_v[2]};
            {m_src_ce, m_src_addr, m_dst_ce, m_dst_we, m_dst_addr, m_dst_d} =
                {bus_c.o_src_ce, bus_c.o_src_addr, bus_c.o_dst_ce, bus_c.o_dst_we,
                 bus_c.o_dst_addr, bus_c.o_dst_d};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s (dut %0d, cycle %0d): got %0d, expected %0d",
                     name, sel, cyc, act, exp);
        end
    endtask

    function automatic int px(input int r, input int c);
        return int'(src_mem[r * cur_w + c]);
    endfunction

    // Reference: each output pixel straight from its 2-D neighbourhood.
    task automatic build_expected();
        int gx, gy, mag, lap, v;
        n_pix = cur_w * cur_h;
        d_exp = (mode == 2'd0) ? n_pix + 4 : n_pix + cur_w + 5;
        for (int r = 0; r < cur_h; r++) begin
            for (int c = 0; c < cur_w; c++) begin
                if (mode == 2'd0) begin
                    v = px(r, c);
                end else if (r == 0 || r == cur_h - 1 || c == 0 || c == cur_w - 1) begin
                    v = 0;
                end else begin
                    gx = px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1)
                       - px(r-1, c-1) - 2*px(r, c-1) - px(r+1, c-1);
                    gy = px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1)
                       - px(r-1, c-1) - 2*px(r-1, c) - px(r-1, c+1);
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                    if (mag > 255) mag = 255;
                    lap = 4*px(r, c) - px(r-1, c) - px(r, c-1) - px(r, c+1) - px(r+1, c);
                    if (lap < 0) lap = 0;
                    if (lap > 255) lap = 255;
                    if (mode == 2'd1)      v = mag;
                    else if (mode == 2'd2) v = (mag >= int'(thr)) ? 255 : 0;
                    else                   v = lap;
                end
                exp_img[r * cur_w + c] = v;
            end
        end
    endtask

    always @(negedge clk) begin
        int exp_we, exp_addr;
        if (active) begin
            cyc++;
            chk("idle", int'(m_idle), int'(cyc > d_exp));
            chk("read", int'(m_read), int'(cyc <= n_pix));
            chk("src_ce", int'(m_src_ce), int'(cyc <= n_pix));
            if (cyc <= n_pix) chk("src_addr", int'(m_src_addr), cyc - 1);
            if (mode == 2'd0) begin
                exp_we   = int'(cyc >= 4 && cyc <= n_pix + 3);
                exp_addr = cyc - 4;
            end else begin
                exp_we   = int'(cyc >= cur_w + 5 && cyc <= n_pix + cur_w + 4);
                exp_addr = cyc - cur_w - 5;
            end
            chk("dst_we", int'(m_dst_we), exp_we);
            chk("dst_ce", int'(m_dst_ce), exp_we);
            chk("write", int'(m_write), exp_we);
            if (exp_we != 0) begin
                chk("dst_addr", int'(m_dst_addr), exp_addr);
                chk("dst_d", int'(m_dst_d), exp_img[exp_addr]);
            end
            chk("done", int'(m_done), int'(cyc == d_exp));
            if (m_done) done_cyc = cyc;
            if (m_dst_we && m_dst_addr < 16'd64) begin
                dst_mem[m_dst_addr[5:0]] = m_dst_d;
                wr_cnt[m_dst_addr[5:0]]++;
            end
        end
    end

    task automatic set_cfg(input int s, input int w, input int h);
        sel   = s;
        cur_w = w;
        cur_h = h;
    endtask

    task automatic load_image(input int pat);
        int r, c;
        for (int i = 0; i < 64; i++) begin
            r = i / cur_w;
            c = i % cur_w;
            if (i >= cur_w * cur_h) src_mem[i] = 8'h00;
            else if (pat == 0)      src_mem[i] = 8'(i);
            else if (pat == 1)      src_mem[i] = 8'h80;
            else if (pat == 2)      src_mem[i] = (c < 3) ? 8'h10 : 8'h50;
            else                    src_mem[i] = (r == 2 && c == 2) ? 8'h10 : 8'h00;
        end
    endtask

    task automatic check_reset();
        chk("rst_idle", int'(m_idle), 1);
        chk("rst_read", int'(m_read), 0);
        chk("rst_write", int'(m_write), 0);
        chk("rst_done", int'(m_done), 0);
        chk("rst_src_ce", int'(m_src_ce), 0);
        chk("rst_src_addr", int'(m_src_addr), 0);
        chk("rst_dst_ce", int'(m_dst_ce), 0);
        chk("rst_dst_we", int'(m_dst_we), 0);
        chk("rst_dst_addr", int'(m_dst_addr), 0);
        chk("rst_dst_d", int'(m_dst_d), 0);
    endtask

    // chained: run is already high and the engine is in IDLE for the coming edge.
    task automatic run_pass(input bit chained, input bit hold);
        int bad;
        build_expected();
        for (int i = 0; i < 64; i++) begin
            dst_mem[i] = 8'hAA;
            wr_cnt[i]  = 0;
        end
        done_cyc = -1;
        if (!chained) begin
            @(negedge clk);
            run = 1'b1;
        end
        @(posedge clk);
        cyc    = 0;
        active = 1'b1;
        #1 run = hold;
        repeat (d_exp + 1) @(negedge clk);
        #1 active = 1'b0;
        bad = 0;
        for (int i = 0; i < n_pix; i++)
            if (wr_cnt[i] != 1 || int'(dst_mem[i]) != exp_img[i]) bad++;
        chk("image", bad, 0);
        chk("done_cycle", done_cyc, d_exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        active   = 1'b0;
        cyc      = 0;
        rst_n    = 1'b0;
        run      = 1'b0;
        mode     = 2'd0;
        thr      = 8'h00;
        set_cfg(0, 4, 4);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check_reset();
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 4x4 ramp copy, run held high so a second pass follows straight from IDLE.
        set_cfg(0, 4, 4);
        load_image(0);
        mode = 2'd0;
        run_pass(1'b0, 1'b1);
        chk("copy_done_cycle", done_cyc, 20);
        chk("copy_px15", int'(dst_mem[15]), 'h0F);
        chk("copy_px5", int'(dst_mem[5]), 'h05);
        run_pass(1'b1, 1'b0);
        chk("chain_done_cycle", done_cyc, 20);

        // 6x5 flat image, Sobel magnitude.
        set_cfg(1, 6, 5);
        load_image(1);
        mode = 2'd1;
        run_pass(1'b0, 1'b0);
        chk("flat_done_cycle", done_cyc, 41);
        chk("flat_px14", int'(dst_mem[14]), 'h00);
        chk("flat_flush23", int'(dst_mem[23]), 'h00);

        // Step edge between columns 2 and 3.
        load_image(2);
        run_pass(1'b0, 1'b0);
        chk("step_c2", int'(dst_mem[14]), 'hFF);
        chk("step_c3", int'(dst_mem[9]), 'hFF);
        chk("step_c1", int'(dst_mem[13]), 'h00);
        chk("step_c4", int'(dst_mem[16]), 'h00);
        chk("step_top", int'(dst_mem[2]), 'h00);

        mode = 2'd2;
        thr  = 8'hFF;
        run_pass(1'b0, 1'b0);
        chk("thr_ff_c2", int'(dst_mem[14]), 'hFF);
        chk("thr_ff_c1", int'(dst_mem[13]), 'h00);
        thr = 8'h00;
        run_pass(1'b0, 1'b0);
        chk("thr_00_c1", int'(dst_mem[13]), 'hFF);
        chk("thr_00_border", int'(dst_mem[6]), 'h00);

        // Abort mid-READ; a run pulse inside READ must not disturb the pass.
        mode = 2'd1;
        build_expected();
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        cyc    = 0;
        active = 1'b1;
        #1 run = 1'b0;
        repeat (4) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (6) @(negedge clk);
        #1 active = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(1'b0, 1'b0);
        chk("rerun_c2", int'(dst_mem[14]), 'hFF);
        chk("rerun_c1", int'(dst_mem[13]), 'h00);

        // 5x5 impulse, Laplacian.
        set_cfg(2, 5, 5);
        load_image(3);
        mode = 2'd3;
        run_pass(1'b0, 1'b0);
        chk("lap_centre", int'(dst_mem[12]), 'h40);
        chk("lap_west", int'(dst_mem[11]), 'h00);
        chk("lap_north", int'(dst_mem[7]), 'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
